// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid lookup-table load path.
package sigmoid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } sigmoid_load_state_t;

  localparam int unsigned SIGMOID_DEPTH  = 32;
  localparam int unsigned SIGMOID_ADDR_W = 5;
  localparam int unsigned SIGMOID_DATA_W = 4;
  localparam int unsigned SIGMOID_SUM_W  = 9;

endpackage

// File: rtl/sigmoid_load_counter.sv
// Table address counter: synchronous clear, increment, and terminal count at DEPTH-1.
module sigmoid_load_counter
  import sigmoid_pkg::*;
#(
  parameter  int unsigned DEPTH  = SIGMOID_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  logic [ADDR_W-1:0] count_q, count_d;

  assign tc    = (count_q == ADDR_W'(DEPTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      // Explicit wrap keeps non-power-of-two depths in range.
      count_d = tc ? '0 : count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sigmoid_table_loader.sv
// Streams DEPTH nibbles into the sigmoid register bank as registered writes.
// Optional load checksum enabled by defining SIGMOID_LOAD_CHECKSUM_EN.
module sigmoid_table_loader
  import sigmoid_pkg::*;
#(
  parameter  int unsigned DEPTH  = SIGMOID_DEPTH,
  parameter  int unsigned DATA_W = SIGMOID_DATA_W,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              load_done,
  output logic              table_valid
`ifdef SIGMOID_LOAD_CHECKSUM_EN
  ,
  input  logic [SIGMOID_SUM_W-1:0] expected_sum,
  output logic                     load_error
`endif
);

  sigmoid_load_state_t state_q, state_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              load_done_q, load_done_d;
  logic              table_valid_q, table_valid_d;

  logic              beat;
  logic              cnt_clr;
  logic              cnt_tc;
  logic [ADDR_W-1:0] cnt;

`ifdef SIGMOID_LOAD_CHECKSUM_EN
  logic [SIGMOID_SUM_W-1:0] sum_q, sum_d, sum_next;
  logic                     load_error_q, load_error_d;

  assign sum_next   = sum_q + SIGMOID_SUM_W'(in_data);
  assign load_error = load_error_q;
`endif

  // Abort masks ready combinationally so a beat coincident with abort is never taken.
  assign in_ready = (state_q == LOAD) && !abort;
  assign beat     = in_ready && in_valid;

  sigmoid_load_counter #(
    .DEPTH (DEPTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (beat),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d       = state_q;
    write_en_d    = 1'b0;
    address_d     = '0;
    data_d        = '0;
    busy_d        = 1'b0;
    load_done_d   = 1'b0;
    table_valid_d = table_valid_q;
    cnt_clr       = 1'b0;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
    sum_d         = sum_q;
    load_error_d  = load_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = LOAD;
          busy_d        = 1'b1;
          cnt_clr       = 1'b1;
          table_valid_d = 1'b0;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          sum_d         = '0;
          load_error_d  = 1'b0;
`endif
        end
      end
      LOAD: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d       = IDLE;
          busy_d        = 1'b0;
          table_valid_d = 1'b0;
        end else if (beat) begin
          write_en_d = 1'b1;
          address_d  = cnt;
          data_d     = in_data;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          sum_d      = sum_next;
`endif
          if (cnt_tc) begin
            // Completion is decided on the last beat so it lands with the last write.
            state_d       = DONE;
            busy_d        = 1'b0;
            load_done_d   = 1'b1;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
            load_error_d  = (sum_next != expected_sum);
            table_valid_d = (sum_next == expected_sum);
`else
            table_valid_d = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      write_en_q    <= 1'b0;
      address_q     <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
      table_valid_q <= 1'b0;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
      sum_q         <= '0;
      load_error_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      write_en_q    <= write_en_d;
      address_q     <= address_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
      table_valid_q <= table_valid_d;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
      sum_q         <= sum_d;
      load_error_q  <= load_error_d;
`endif
    end
  end

  assign write_en    = write_en_q;
  assign address_out = address_q;
  assign data_out    = data_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;
  assign table_valid = table_valid_q;

endmodule

// File: tb/tb_sigmoid_table_loader.sv
// Randomized and directed bench for sigmoid_table_loader against a cycle-level reference model.
module tb_sigmoid_table_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid;
  logic [3:0] in_data;
  logic       in_ready, write_en, busy, load_done, table_valid;
  logic [4:0] address_out;
  logic [3:0] data_out;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
  logic [8:0] expected_sum;
  logic       load_error;
`endif

  always #5 clk = ~clk;

  sigmoid_table_loader #(
    .DEPTH  (32),
    .DATA_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .write_en    (write_en),
    .address_out (address_out),
    .data_out    (data_out),
    .busy        (busy),
    .load_done   (load_done),
    .table_valid (table_valid)
`ifdef SIGMOID_LOAD_CHECKSUM_EN
    ,
    .expected_sum (expected_sum),
    .load_error   (load_error)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int we_seen = 0;
  int ld_seen = 0;
  int ld_cyc  = -1;

  // Reference model: whether a load is running, how many entries are written,
  // and what the bank port should show in the cycle after each decision.
  bit         m_load = 0, m_done = 0, m_tv = 0, m_we = 0, m_ld = 0, m_err = 0;
  int         m_cnt = 0, m_sum = 0, exp_sum = 480;
  logic [4:0] m_addr = '0;
  logic [3:0] m_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic s, input logic a, input logic v, input logic [3:0] d, input logic r);
    bit beat, last;
    start = s; abort = a; in_valid = v; in_data = d; rst = r;
    #1;
    check_eq("in_ready", in_ready, (m_load && !a));
    check_eq("busy", busy, m_load);
    check_eq("write_en", write_en, m_we);
    check_eq("address_out", address_out, m_addr);
    check_eq("data_out", data_out, m_data);
    check_eq("load_done", load_done, m_ld);
    check_eq("table_valid", table_valid, m_tv);
`ifdef SIGMOID_LOAD_CHECKSUM_EN
    check_eq("load_error", load_error, m_err);
`endif
    if (write_en === 1'b1) we_seen++;
    if (load_done === 1'b1) begin
      ld_seen++;
      ld_cyc = cyc;
    end
    if (r) begin
      m_load = 0; m_done = 0; m_tv = 0; m_we = 0; m_ld = 0; m_err = 0;
      m_cnt = 0; m_sum = 0; m_addr = '0; m_data = '0;
    end else begin
      beat   = m_load && !a && v;
      last   = beat && (m_cnt == 31);
      m_we   = beat;
      m_addr = beat ? 5'(m_cnt) : 5'd0;
      m_data = beat ? d : 4'd0;
      m_ld   = last;
      if (m_done) begin
        m_done = 0;
      end else if (!m_load) begin
        if (s && !a) begin
          m_load = 1; m_cnt = 0; m_tv = 0; m_sum = 0; m_err = 0;
        end
      end else if (a) begin
        m_load = 0; m_tv = 0;
      end else if (beat) begin
        m_sum += int'(d);
        if (last) begin
          m_load = 0; m_done = 1; m_cnt = 0;
          m_err  = (m_sum != exp_sum);
`ifdef SIGMOID_LOAD_CHECKSUM_EN
          m_tv   = !m_err;
`else
          m_tv   = 1;
`endif
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'($urandom), 0);
  endtask

  int st;

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; in_data = '0;
`ifdef SIGMOID_LOAD_CHECKSUM_EN
    expected_sum = 9'd480;
`endif
    exp_sum = 480;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle(2);

    // Basic load with ramp data.
    we_seen = 0; ld_seen = 0; st = cyc;
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 4'(i % 16), 0);
    idle(2);
    check_eq("basic_writes", 32'(we_seen), 32);
    check_eq("basic_done_count", 32'(ld_seen), 1);
    check_eq("basic_done_latency", 32'(ld_cyc - st + 1), 34);
    check_eq("basic_table_valid", table_valid, 1);

    // Stall after beat 10.
    we_seen = 0;
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, 4'($urandom), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 4'($urandom), 0);
    for (int i = 0; i < 21; i++) cycle(0, 0, 1, 4'($urandom), 0);
    idle(2);
    check_eq("stall_writes", 32'(we_seen), 32);

    // Abort after 5 beats with a beat presented.
    we_seen = 0;
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 4'($urandom), 0);
    cycle(0, 1, 1, 4'($urandom), 0);
    idle(3);
    check_eq("abort_writes", 32'(we_seen), 5);
    check_eq("abort_table_valid", table_valid, 0);

    // Restart with start held during the load.
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 32; i++) cycle(1, 0, 1, 4'($urandom), 0);
    idle(1);
    // start and abort together in IDLE.
    cycle(1, 1, 1, 4'd3, 0);
    idle(2);
    // Abort presented in the DONE cycle.
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 4'($urandom), 0);
    cycle(0, 1, 0, 4'd0, 0);
    idle(1);
    check_eq("abort_in_done_tv", table_valid, 1);

    // Reset at beat 20.
    we_seen = 0;
    cycle(1, 0, 0, 4'd0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 4'($urandom), 0);
    cycle(0, 0, 1, 4'($urandom), 1);
    idle(4);
    check_eq("reset_writes", 32'(we_seen), 20);

`ifdef SIGMOID_LOAD_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      exp_sum = (k == 0) ? 480 : 479;
      expected_sum = 9'(exp_sum);
      cycle(1, 0, 0, 4'd0, 0);
      for (int i = 0; i < 32; i++) cycle(0, 0, 1, 4'hF, 0);
      idle(2);
      check_eq("csum_error", load_error, (k == 1));
      check_eq("csum_table_valid", table_valid, (k == 0));
    end
    cycle(1, 0, 0, 4'd0, 0);
    check_eq("csum_error_cleared", load_error, 0);
    cycle(0, 1, 0, 4'd0, 0);
    idle(1);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 8) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
            4'($urandom), ($urandom % 500) == 0);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigmoid_table_loader.md
# sigmoid_table_loader

Sequencing controller for the 32-entry × 4-bit sigmoid lookup register bank. On a start command it accepts 32 nibbles over a valid/ready stream and issues one registered write per nibble, at addresses 0 through 31 in order. It reports completion and tracks whether the table contents are valid. It sits between the coefficient-load path and the bank of addressable sigmoid registers, and is the only writer of that bank.

## Interface
Parameters:
- DEPTH, 32: number of table entries; the address width is $clog2(DEPTH) = 5.
- DATA_W, 4: entry width in bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a table load; sampled only in IDLE.
- abort  in  1  cancel a load in progress.
- in_valid  in  1  in_data is valid.
- in_data  in  4  table entry value.
- in_ready  out  1  loader accepts in_data this cycle.
- write_en  out  1  registered write strobe to the register bank.
- address_out  out  5  registered bank address.
- data_out  out  4  registered bank write data.
- busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when the last entry is written.
- table_valid  out  1  level; the bank holds a complete table.
- expected_sum  in  9  present only with SIGMOID_LOAD_CHECKSUM_EN.
- load_error  out  1  present only with SIGMOID_LOAD_CHECKSUM_EN.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE:
  - start=1 and abort=0: go to LOAD, clear the address counter, clear table_valid.
  - start and abort both 1: stay in IDLE; table_valid is unchanged.
- LOAD:
  - in_ready = 1 and busy = 1.
  - A beat transfers when in_valid && in_ready.
  - On each beat, the next cycle has write_en=1, address_out=counter, data_out=in_data, and the counter increments.
  - The beat at counter = DEPTH-1 moves the FSM to DONE. The counter wraps to 0 and is not reused.
  - abort=1 moves the FSM to IDLE with table_valid=0. A beat presented in the same cycle as abort is not accepted (in_ready=0 when abort=1).
  - start is ignored in LOAD.
- DONE (one cycle):
  - load_done=1, table_valid goes to 1, in_ready=0.
  - Return to IDLE.
  - abort in DONE is ignored, because the table is already complete.
- write_en, address_out and data_out are 0 in every cycle that does not follow an accepted beat.
- in_valid stalls in LOAD are legal and unbounded; the counter holds during a stall.
- There is exactly one write per accepted beat. No address is skipped or written twice within a load.

## Timing
- Reset values: state=IDLE, counter=0; in_ready, write_en, address_out, data_out, busy, load_done, table_valid and load_error are all 0.
- Reset mid-load returns the block to IDLE in the next cycle with table_valid=0. A write strobe pending from the previous cycle is dropped.
- start in IDLE at cycle T gives in_ready=1 at T+1.
- A beat accepted at cycle T produces write_en at T+1.
- The last beat at T gives write_en at T+1 together with load_done=1 and table_valid=1 at T+1 (the DONE cycle).
- Back-to-back beats sustain one write per cycle. A full load with no stalls takes 34 cycles from start to load_done.

## Configuration
- Macro SIGMOID_LOAD_CHECKSUM_EN.
- Defined:
  - A 9-bit accumulator clears on entry to LOAD and adds each accepted in_data (zero-extended).
  - In DONE, load_error = (sum != expected_sum). load_error is held until the next start or rst.
  - When load_error is set, table_valid stays 0.
- Undefined: the expected_sum and load_error ports and the accumulator are absent, and table_valid is set unconditionally in DONE.

## Structure
- Shared package sigmoid_pkg holds:
  - the state enum type sigmoid_load_state_t (IDLE, LOAD, DONE);
  - the constants SIGMOID_DEPTH=32, SIGMOID_ADDR_W=5, SIGMOID_DATA_W=4;
  - the checksum width constant SIGMOID_SUM_W=9.
- One natural sub-module: sigmoid_load_counter. It is a 5-bit address counter with clear, increment and terminal-count outputs.

## Test plan
- Basic load: rst, then start; stream nibbles i%16 for i=0..31 with in_valid held high. Expect 32 write_en pulses, address_out 0..31, data_out = i%16, load_done exactly once at cycle 34, and table_valid=1.
- Stall handling: drop in_valid for 3 cycles after beat 10. Expect in_ready to stay 1, no write_en during the stall, and address 11 written on the next valid beat with no gap or duplicate.
- Mid-load abort: assert abort with in_valid=1 after 5 beats. Expect no 6th write, FSM in IDLE, and table_valid=0. A subsequent start must restart writes at address 0.
- Ignored commands: start during LOAD is ignored (address sequence unaffected); start and abort together in IDLE leave the block in IDLE; abort in DONE still yields table_valid=1.
- Reset mid-load: rst at beat 20. Expect all outputs 0 in the next cycle and no write_en afterwards.
- Checksum (macro defined): stream all 0xF nibbles with expected_sum=480. Expect load_error=0 and table_valid=1. Repeat with expected_sum=479. Expect load_error=1, table_valid=0, and load_error cleared on the next start.
